decoder_2421_seq_checker: RTL and testbench

//  Receiving end of the 2421-code decade counter link. Samples a 4-bit 2421 code per valid beat,

---
 rtl/decoder_2421_seq_checker.sv | 101 ++++++++++
 tb/tb_decoder_2421_seq_checker.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/decoder_2421_seq_checker.sv
// decoder_2421_seq_checker: decodes 2421-coded digits and checks decade count order, wraps and lock state
module decoder_2421_seq_checker #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       code_in,
  input  logic             code_valid,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             wrap,
  output logic [CNT_W-1:0] decade_cnt,
  output logic             locked
);
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
  localparam logic [3:0] LOCK_V = 4'(LOCK_N);
  localparam logic       ONE_LOCK = (LOCK_N == 1);
  state_t     state;
  logic [3:0] run;
  logic [3:0] dec;
  logic       legal;
  logic [3:0] succ;
  logic       in_order;
  always_comb begin
    dec   = 4'd0;
    legal = 1'b1;
    case (code_in)
      4'b0000: dec = 4'd0;
      4'b0001: dec = 4'd1;
      4'b0010: dec = 4'd2;
      4'b0011: dec = 4'd3;
      4'b0100: dec = 4'd4;
      4'b1011: dec = 4'd5;
      4'b1100: dec = 4'd6;
      4'b1101: dec = 4'd7;
      4'b1110: dec = 4'd8;
      4'b1111: dec = 4'd9;
      default: legal = 1'b0;
    endcase
  end
  assign succ     = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  assign in_order = legal && (dec == succ);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      run         <= 4'd0;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      wrap        <= 1'b0;
      decade_cnt  <= '0;
      locked      <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      wrap        <= 1'b0;
      if (code_valid && !legal) begin
        illegal <= 1'b1;
        state   <= IDLE;
        run     <= 4'd0;
        locked  <= 1'b0;
      end else if (code_valid) begin
        digit       <= dec;
        digit_valid <= 1'b1;
        case (state)
          IDLE: begin
            run    <= 4'd1;
            state  <= ONE_LOCK ? LOCKED : SYNC;
            locked <= ONE_LOCK;
          end
          SYNC: begin
            // run is below LOCK_N here, so the increment cannot overflow
            run <= in_order ? run + 4'd1 : 4'd1;
            if (in_order && (run + 4'd1 >= LOCK_V)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          default: begin
            if (in_order) begin
              if (dec == 4'd0) begin
                wrap       <= 1'b1;
                decade_cnt <= decade_cnt + CNT_W'(1);
              end
            end else begin
              seq_err <= 1'b1;
              run     <= 4'd1;
              state   <= ONE_LOCK ? LOCKED : SYNC;
              locked  <= ONE_LOCK;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_decoder_2421_seq_checker.sv
// tb_decoder_2421_seq_checker: directed literal checks plus random stimulus against a behavioural model
module tb_decoder_2421_seq_checker;
  localparam int CNT_W  = 2;
  localparam int LOCK_N = 3;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       code_in = 4'd0;
  logic             code_valid = 1'b0;
  logic [3:0]       digit;
  logic             digit_valid, illegal, seq_err, wrap, locked;
  logic [CNT_W-1:0] decade_cnt;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int lut[16] = '{0, 1, 2, 3, 4, -1, -1, -1, -1, -1, -1, 5, 6, 7, 8, 9};
  int enc[10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
  int m_prev = -1, m_run = 0, m_locked = 0, m_dec = 0, m_digit = 0;
  int m_dv = 0, m_ill = 0, m_se = 0, m_wrap = 0;

  decoder_2421_seq_checker #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .digit(digit), .digit_valid(digit_valid), .illegal(illegal), .seq_err(seq_err),
    .wrap(wrap), .decade_cnt(decade_cnt), .locked(locked)
  );

  always #5 clk = ~clk;

  // Model: tracks the previous legal digit and length of the current in-order run
  always @(posedge clk) begin
    int d;
    m_dv = 0; m_ill = 0; m_se = 0; m_wrap = 0;
    if (!rst_n) begin
      m_prev = -1; m_run = 0; m_locked = 0; m_dec = 0; m_digit = 0;
    end else if (code_valid) begin
      d = lut[code_in];
      if (d < 0) begin
        m_ill = 1; m_prev = -1; m_run = 0; m_locked = 0;
      end else begin
        m_dv = 1;
        if (m_prev >= 0 && d == (m_prev + 1) % 10) begin
          m_run = (m_run + 1 > LOCK_N) ? LOCK_N : m_run + 1;
          if (m_locked && m_prev == 9) begin
            m_wrap = 1;
            m_dec = (m_dec + 1) % (1 << CNT_W);
          end
          if (m_run >= LOCK_N) m_locked = 1;
        end else begin
          if (m_locked) m_se = 1;
          m_run = 1;
          m_locked = (LOCK_N == 1) ? 1 : 0;
        end
        m_prev = d;
        m_digit = d;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_digit", int'(digit), m_digit);
      chk("m_digit_valid", int'(digit_valid), m_dv);
      chk("m_illegal", int'(illegal), m_ill);
      chk("m_seq_err", int'(seq_err), m_se);
      chk("m_wrap", int'(wrap), m_wrap);
      chk("m_decade_cnt", int'(decade_cnt), m_dec);
      chk("m_locked", int'(locked), m_locked);
    end
  end

  task automatic beat(input logic r, input logic v, input logic [3:0] c);
    @(negedge clk);
    rst_n = r; code_valid = v; code_in = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v;
    beat(1'b0, 1'b1, 4'b0101);
    beat(1'b0, 1'b0, 4'b0000);
    chk_en = 1'b1;
    chk("rst_digit", int'(digit), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_dc", int'(decade_cnt), 0);
    chk("rst_pulses", int'({digit_valid, illegal, seq_err, wrap}), 0);
    // bring-up 0,1,2 then lock
    beat(1'b1, 1'b1, 4'b0000);
    chk("t1_d0", int'(digit), 0); chk("t1_dv0", int'(digit_valid), 1); chk("t1_lk0", int'(locked), 0);
    beat(1'b1, 1'b1, 4'b0001);
    chk("t1_d1", int'(digit), 1); chk("t1_lk1", int'(locked), 0);
    beat(1'b1, 1'b1, 4'b0010);
    chk("t1_d2", int'(digit), 2); chk("t1_lk2", int'(locked), 1);
    foreach (enc[i]) if (i >= 3 && i <= 7) beat(1'b1, 1'b1, 4'(enc[i]));
    beat(1'b1, 1'b1, 4'b1110);
    chk("t2_d8", int'(digit), 8); chk("t2_w8", int'(wrap), 0);
    beat(1'b1, 1'b1, 4'b1111);
    chk("t2_d9", int'(digit), 9); chk("t2_w9", int'(wrap), 0); chk("t2_dc9", int'(decade_cnt), 0);
    beat(1'b1, 1'b1, 4'b0000);
    chk("t2_d0", int'(digit), 0); chk("t2_w0", int'(wrap), 1); chk("t2_dc0", int'(decade_cnt), 1);
    for (int i = 1; i <= 4; i++) beat(1'b1, 1'b1, 4'(enc[i]));
    chk("t3_d4", int'(digit), 4); chk("t3_lk4", int'(locked), 1);
    beat(1'b1, 1'b1, 4'b1011);
    chk("t3_d5", int'(digit), 5); chk("t3_se5", int'(seq_err), 0);
    beat(1'b1, 1'b1, 4'b0000);
    chk("t3_se", int'(seq_err), 1); chk("t3_d0", int'(digit), 0); chk("t3_lk", int'(locked), 0);
    beat(1'b1, 1'b1, 4'b0110);
    chk("t4_ill", int'(illegal), 1); chk("t4_dv", int'(digit_valid), 0);
    chk("t4_d", int'(digit), 0); chk("t4_lk", int'(locked), 0);
    beat(1'b1, 1'b1, 4'b0001);
    beat(1'b1, 1'b1, 4'b0010);
    beat(1'b1, 1'b1, 4'b0011);
    chk("t5_lk", int'(locked), 1);
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, 1'b0, 4'(i));
      chk("t5_idle_pulses", int'({digit_valid, illegal, seq_err, wrap}), 0);
      chk("t5_idle_hold", int'({locked, digit}), 16 + 3);
    end
    chk("t5_dc_hold", int'(decade_cnt), 1);
    beat(1'b1, 1'b1, 4'b0100);
    chk("t5_resume_se", int'(seq_err), 0); chk("t5_resume_d", int'(digit), 4);
    beat(1'b0, 1'b1, 4'b1011);
    chk("t5_rst_d", int'(digit), 0); chk("t5_rst_lk", int'(locked), 0);
    chk("t5_rst_dc", int'(decade_cnt), 0); chk("t5_rst_dv", int'(digit_valid), 0);
    // four full decades roll the 2-bit counter back to zero
    for (int i = 0; i <= 40; i++) begin
      beat(1'b1, 1'b1, 4'(enc[i % 10]));
      if (i > 0 && i % 10 == 0) begin
        chk("t6_wrap", int'(wrap), 1);
        chk("t6_dc", int'(decade_cnt), (i / 10) % 4);
      end
    end
    for (int i = 0; i < 10000; i++) begin
      v = $urandom_range(0, 99);
      if (v < 1) beat(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      else if (v < 15) beat(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      else if (v < 60) beat(1'b1, 1'b1, 4'(enc[(m_digit + 1) % 10]));
      else if (v < 85) beat(1'b1, 1'b1, 4'(enc[$urandom_range(0, 9)]));
      else beat(1'b1, 1'b1, 4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
